// File: rtl/mem_access.sv
// Memory stage: drives a req/ack data bus for byte/half/word loads and stores,
// stalls upstream while an access is outstanding, and reports misalignment/timeouts.
module mem_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_memRead,
   input  logic        i_memWrite,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_stall,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_addr_error,
   output logic        o_bus_error,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_be,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic        addr_err_q, addr_err_d, bus_err_q, bus_err_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  size_q, size_d, off_q, off_d;
   logic        signed_q, signed_d;

   logic        start, is_byte, is_half, misaligned;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc, load_fmt;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign start      = i_valid & (i_memRead | i_memWrite);
   assign is_byte    = (i_size == 2'b00);
   assign is_half    = (i_size == 2'b01);
   assign misaligned = (is_half & i_addr[0]) | (!is_byte & !is_half & (i_addr[1:0] != 2'b00));

   // Big-endian lanes: offset 0 is bits 31:24.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = i_wdata;
      if (is_byte) begin
         be_calc    = 4'b1000 >> i_addr[1:0];
         wdata_calc = {4{i_wdata[7:0]}};
      end else if (is_half) begin
         be_calc    = i_addr[1] ? 4'b0011 : 4'b1100;
         wdata_calc = {2{i_wdata[15:0]}};
      end
   end

   always_comb begin
      case (off_q)
         2'd0:    lane_b = i_dmem_rdata[31:24];
         2'd1:    lane_b = i_dmem_rdata[23:16];
         2'd2:    lane_b = i_dmem_rdata[15:8];
         default: lane_b = i_dmem_rdata[7:0];
      endcase
      lane_h = off_q[1] ? i_dmem_rdata[15:0] : i_dmem_rdata[31:16];
      case (size_q)
         2'b00:   load_fmt = {{24{signed_q & lane_b[7]}}, lane_b};
         2'b01:   load_fmt = {{16{signed_q & lane_h[15]}}, lane_h};
         default: load_fmt = i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdata_d    = rdata_q;
      addr_err_d = addr_err_q;
      bus_err_d  = bus_err_q;
      cnt_d      = cnt_q;
      size_d     = size_q;
      off_d      = off_q;
      signed_d   = signed_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (misaligned) begin
                  addr_err_d = 1'b1;
                  state_d    = DONE;
               end else begin
                  req_d    = 1'b1;
                  we_d     = i_memWrite;
                  addr_d   = {i_addr[31:2], 2'b00};
                  wdata_d  = wdata_calc;
                  be_d     = be_calc;
                  size_d   = i_size;
                  off_d    = i_addr[1:0];
                  signed_d = i_signed;
                  cnt_d    = '0;
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            // An ack in the expiry cycle takes priority over the timeout.
            if (i_dmem_ack) begin
               req_d = 1'b0;
               if (!we_q) rdata_d = load_fmt;
               state_d = DONE;
            end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         DONE: begin
            addr_err_d = 1'b0;
            bus_err_d  = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdata_q    <= '0;
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
         cnt_q      <= '0;
         size_q     <= '0;
         off_q      <= '0;
         signed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rdata_q    <= rdata_d;
         addr_err_q <= addr_err_d;
         bus_err_q  <= bus_err_d;
         cnt_q      <= cnt_d;
         size_q     <= size_d;
         off_q      <= off_d;
         signed_q   <= signed_d;
      end
   end

   assign o_stall      = ((state_q == IDLE) & start) | (state_q == BUSY);
   assign o_done       = (state_q == DONE);
   assign o_rdata      = rdata_q;
   assign o_addr_error = addr_err_q;
   assign o_bus_error  = bus_err_q;
   assign o_dmem_req   = req_q;
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed accesses push expected completions,
// a monitor compares them whenever o_done pulses.
module tb_mem_access;

   logic        i_clk = 1'b0;
   logic        i_rst, i_valid, i_memRead, i_memWrite, i_signed;
   logic [1:0]  i_size;
   logic [31:0] i_addr, i_wdata;
   logic        o_stall, o_done, o_addr_error, o_bus_error;
   logic [31:0] o_rdata;
   logic        o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        ae;
      logic        be;
   } exp_t;
   exp_t sb[$];

   mem_access #(.TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_memRead(i_memRead),
      .i_memWrite(i_memWrite), .i_size(i_size), .i_signed(i_signed),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
      .o_rdata(o_rdata), .o_addr_error(o_addr_error), .o_bus_error(o_bus_error),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every o_done must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      if (o_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", o_rdata, e.rdata);
            chk("addr_error", {31'd0, o_addr_error}, {31'd0, e.ae});
            chk("bus_error", {31'd0, o_bus_error}, {31'd0, e.be});
         end
      end
   end

   // ack_at: BUSY cycle index (0-based) where ack is driven; -1 means never.
   task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] ack_data,
                         input logic [31:0] exp_rdata, input logic exp_ae, input logic exp_berr,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input int exp_req_cycles);
      exp_t e;
      int   nreq;
      bit   ended;
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_memRead = rd; i_memWrite = wr; i_size = sz; i_signed = sg;
      i_addr = addr; i_wdata = wd;
      @(negedge i_clk);
      chk("stall_start", {31'd0, o_stall}, 32'd1);
      e.rdata = exp_rdata; e.ae = exp_ae; e.be = exp_berr;
      sb.push_back(e);
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
      nreq = 0;
      ended = 1'b0;
      for (int c = 0; c < 40; c++) begin
         i_dmem_ack   = (c == ack_at);
         i_dmem_rdata = ack_data;
         @(negedge i_clk);
         if (!o_dmem_req) begin
            ended = 1'b1;
            break;
         end
         nreq++;
         chk("busy_stall", {31'd0, o_stall}, 32'd1);
         chk("bus_we", {31'd0, o_dmem_we}, {31'd0, exp_we});
         chk("bus_addr", o_dmem_addr, exp_addr);
         chk("bus_be", {28'd0, o_dmem_be}, {28'd0, exp_be});
         chk("bus_wdata", o_dmem_wdata, exp_wdata);
         @(posedge i_clk); #1;
      end
      if (!ended) chk("access_ended", 32'd0, 32'd1);
      chk("req_cycles", nreq, exp_req_cycles);
      chk("done_pulse", {31'd0, o_done}, 32'd1);
      chk("done_stall", {31'd0, o_stall}, 32'd0);
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
      @(negedge i_clk);
      chk("idle_done_low", {31'd0, o_done}, 32'd0);
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
      i_size = 2'b00; i_signed = 1'b0; i_addr = '0; i_wdata = '0;
      i_dmem_ack = 1'b0; i_dmem_rdata = '0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      chk("rst_be", {28'd0, o_dmem_be}, 32'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      //     rd    wr    sz     sg    addr          wdata         ack rdata_bus     exp_rdata     ae    berr  we    bus_addr      be       bus_wdata     reqs
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1);
      access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0, 32'h0000_00F0, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0001, 32'h0, 1);
      access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0, 2);
      access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h55, 3, 32'hFFFF_FFFF, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 4'b0100, 32'h5555_5555, 4);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h0, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, 0);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, -1, 32'h0, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 32'h0000_0300, 4'b1111, 32'h0, 4);
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 4'b1111, 32'h0, 4);
      access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0, 0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0, 1);
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 2, 32'h00AB_0000, 32'h0000_00AB, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0, 3);
      access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_BEEF, 0, 32'h0, 32'h0000_00AB, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 4'b0011, 32'hBEEF_BEEF, 1);
      access(1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0104, 32'h0, 0, 32'h1122_3344, 32'h1122_3344, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1);
      access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0000_A5A5, 0, 32'h7777_7777, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 4'b1111, 32'h0000_A5A5, 1);
      access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_1111, 0, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 32'h0, 4'b0, 32'h0, 0);
      access(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0108, 32'h0, 1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 4'b1111, 32'h0, 2);

      // Reset during the second BUSY cycle of a load, followed by a stray ack.
      @(posedge i_clk); #1;
      i_valid = 1'b1; i_memRead = 1'b1; i_size = 2'b10; i_addr = 32'h0000_0500;
      @(posedge i_clk); #1;
      i_valid = 1'b0; i_memRead = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("pre_rst_req", {31'd0, o_dmem_req}, 32'd1);
      @(posedge i_clk); #1;
      i_rst = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
      @(negedge i_clk);
      chk("post_rst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("post_rst_addr", o_dmem_addr, 32'd0);
      chk("post_rst_be", {28'd0, o_dmem_be}, 32'd0);
      chk("post_rst_rdata", o_rdata, 32'd0);
      chk("post_rst_stall", {31'd0, o_stall}, 32'd0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("late_ack_done", {31'd0, o_done}, 32'd0);
      chk("late_ack_rdata", o_rdata, 32'd0);
      chk("late_ack_req", {31'd0, o_dmem_req}, 32'd0);
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0;
      repeat (2) @(posedge i_clk);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage: consumes the ALU result as effective address and the forwarded second operand as store data.
- Performs byte/halfword/word loads and stores on a word-wide data-memory bus with a req/ack handshake and arbitrary wait states.
- Stalls the pipeline while an access is outstanding, formats load data, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, cycles allowed in BUSY without ack before a bus error is raised; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  instruction present in MEM stage
- i_memRead  in  1  load
- i_memWrite  in  1  store
- i_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as word
- i_signed  in  1  load sign-extend (1) / zero-extend (0)
- i_addr  in  32  effective address (ALU result)
- i_wdata  in  32  store data (operand 2)
- o_stall  out  1  hold all upstream stages
- o_done  out  1  one-cycle pulse: access finished
- o_rdata  out  32  formatted load result
- o_addr_error  out  1  misaligned access, valid with o_done
- o_bus_error  out  1  timeout, valid with o_done
- o_dmem_req  out  1  bus request
- o_dmem_we  out  1  write enable
- o_dmem_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables, be[3] = bits 31:24
- i_dmem_ack  in  1  bus completion
- i_dmem_rdata  in  32  read word, valid with ack

Behaviour:
- Reset: state=IDLE. o_dmem_req/we/addr/wdata/be=0, o_rdata=0, o_done=0, both error flags 0, wait counter=0. Reset mid-access drops req immediately. A late ack after reset is ignored.
- start = i_valid & (i_memRead | i_memWrite). If both are set, the access is a write.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- o_stall (combinational) = (IDLE & start) | BUSY.
- In IDLE without start: o_stall=0, nothing registered, the instruction passes through.
- IDLE & start & aligned -> BUSY.
  - Register req=1, we, addr, be and wdata.
  - Clear the counter.
- IDLE & start & misaligned -> DONE.
  - Set addr_error=1.
  - No bus request is issued.
- BUSY: req and all bus outputs are held stable until ack.
  - ack: req=0. For a load, register formatted o_rdata. Go to DONE.
  - No ack: counter++. When counter reaches TIMEOUT-1 with no ack, req=0, bus_error=1, go to DONE.
  - Ack arriving in the expiry cycle wins; bus_error stays 0.
- DONE (one cycle): o_done=1, o_stall=0, so upstream advances this cycle. Error flags are valid this cycle only. Next state is IDLE. Inputs in DONE are ignored.
- Minimum latency: start in cycle N, req in N+1, ack in N+1, o_done in N+2.
- Byte lanes are big-endian: addr[1:0]=0 maps to bits 31:24, 3 maps to 7:0.
  - Byte: be=4'b1000>>addr[1:0].
  - Half: be=1100 for addr[1]=0, 0011 for addr[1]=1.
  - Word: be=1111.
- Store data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load extraction: select the addressed lane, then sign- or zero-extend per i_signed. Word loads ignore i_signed.
- o_rdata holds its last value across stores, errors and idle cycles.
- Ack outside BUSY is ignored.

Test Plan:
- Aligned word load, addr=0x100, ack on the first req cycle, rdata=0xDEADBEEF -> o_stall high 2 cycles; o_done at N+2; o_rdata=0xDEADBEEF; o_dmem_addr=0x100; be=1111; we=0.
- Signed byte load, addr=0x103, rdata=0x000000F0 -> o_rdata=0xFFFFFFF0. Unsigned halfword load, addr=0x102, rdata=0x1234ABCD -> o_rdata=0x0000ABCD.
- Byte store, addr=0x201, wdata=0x00000055, ack after 3 wait cycles -> wdata=0x55555555; be=0100; req, addr and be stable for all 4 BUSY cycles; o_stall high 5 cycles.
- Misaligned word load, addr=0x102 -> req never asserted; o_addr_error=1 and o_done=1 in cycle N+1; o_rdata unchanged.
- TIMEOUT=4, no ack -> req high exactly 4 cycles then drops; o_bus_error=1 with o_done. Rerun with ack in the 4th cycle -> normal completion, bus_error=0.
- i_rst in the second BUSY cycle of a load -> next cycle req=0, state IDLE, all outputs 0; a subsequent ack has no effect.
